// File: rtl/rotate_sched_pkg.sv
// Shared types and default sizing for the rotate batch scheduler and its watchdog.
package rotate_sched_pkg;

   localparam int DEF_IDX_W   = 10;
   localparam int DEF_TIMEOUT = 4096;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_WAIT    = 3'd2,
      ST_RELEASE = 3'd3,
      ST_DONE    = 3'd4
   } sched_state_t;

endpackage

// File: rtl/rotate_watchdog.sv
// Saturating cycle counter: clear restarts it, enable advances it, expired flags TIMEOUT-1.
module rotate_watchdog #(
   parameter int TIMEOUT = 4096
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable && !expired) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign expired = (cnt == LIMIT);

endmodule

// File: rtl/rotate_batch_scheduler.sv
// Issues one rotate start per file over a contiguous index range, with a per-file watchdog.
module rotate_batch_scheduler
   import rotate_sched_pkg::*;
#(
   parameter int IDX_W   = DEF_IDX_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             batch_start,
   input  logic [IDX_W-1:0] base_index,
   input  logic [IDX_W-1:0] num_files,
   input  logic             abort,
   output logic             rot_start,
   input  logic             rot_finish,
   output logic [IDX_W-1:0] file_index,
   output logic             busy,
   output logic             batch_done,
   output logic             timeout_err,
   output logic [IDX_W-1:0] files_done,
   output sched_state_t     state_dbg
);

   // Handshake: batch_start is a one-cycle request honoured only in IDLE; rot_start is a
   // one-cycle pulse per file; rot_finish (pulse or level) is honoured from the first WAIT
   // cycle and must return low before the next file is issued.

   sched_state_t     state, next_state;
   logic [IDX_W-1:0] remaining;
   logic             accept, finish_take, timeout_hit, advance;
   logic             wd_clear, wd_enable, wd_expired;

   always_comb begin
      next_state  = state;
      accept      = 1'b0;
      finish_take = 1'b0;
      timeout_hit = 1'b0;
      advance     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (batch_start) begin
               accept     = 1'b1;
               next_state = (num_files == '0) ? ST_DONE : ST_ISSUE;
            end
         end
         ST_ISSUE: next_state = ST_WAIT;
         ST_WAIT: begin
            if (rot_finish) begin
               finish_take = 1'b1;
               next_state  = ST_RELEASE;
            end else if (wd_expired) begin
               timeout_hit = 1'b1;
               next_state  = ST_IDLE;
            end
         end
         ST_RELEASE: begin
            if (!rot_finish) begin
               if (remaining == '0) begin
                  next_state = ST_DONE;
               end else begin
                  advance    = 1'b1;
                  next_state = ST_ISSUE;
               end
            end
         end
         ST_DONE: next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
      if (abort) begin
         next_state  = ST_IDLE;
         accept      = 1'b0;
         finish_take = 1'b0;
         timeout_hit = 1'b0;
         advance     = 1'b0;
      end
   end

   // Clearing on entry to ISSUE makes the ISSUE cycle the watchdog's first counted cycle.
   assign wd_clear  = (next_state == ST_ISSUE);
   assign wd_enable = (state == ST_ISSUE) || (state == ST_WAIT);

   rotate_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (wd_clear),
      .enable  (wd_enable),
      .expired (wd_expired)
   );

   // Status outputs are registered from next_state so they line up with the state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         rot_start   <= 1'b0;
         busy        <= 1'b0;
         batch_done  <= 1'b0;
         timeout_err <= 1'b0;
         file_index  <= '0;
         files_done  <= '0;
         remaining   <= '0;
      end else begin
         state      <= next_state;
         rot_start  <= (next_state == ST_ISSUE);
         busy       <= (next_state != ST_IDLE);
         batch_done <= (next_state == ST_DONE);
         if (accept) begin
            file_index  <= base_index;
            remaining   <= num_files;
            files_done  <= '0;
            timeout_err <= 1'b0;
         end
         if (finish_take) begin
            files_done <= files_done + IDX_W'(1);
            remaining  <= remaining - IDX_W'(1);
         end
         if (advance) begin
            file_index <= file_index + IDX_W'(1);
         end
         if (timeout_hit) begin
            timeout_err <= 1'b1;
         end
      end
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_rotate_batch_scheduler.sv
// Scoreboarded bench: a rotate engine model answers starts, a monitor checks every pulse.
module tb_rotate_batch_scheduler;
   import rotate_sched_pkg::*;

   localparam int IDX_W = 10;
   localparam int NIDX  = 1 << IDX_W;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic             batch_start, abort, rot_finish;
   logic [IDX_W-1:0] base_index, num_files;
   logic             rot_start, busy, batch_done, timeout_err;
   logic [IDX_W-1:0] file_index, files_done;
   sched_state_t     state_dbg;

   logic             s_start, s_finish;
   logic             s_rot_start, s_busy, s_batch_done, s_timeout_err;
   logic [IDX_W-1:0] s_file_index, s_files_done;
   sched_state_t     s_state_dbg;

   rotate_batch_scheduler #(.IDX_W(IDX_W), .TIMEOUT(64)) dut (
      .clk(clk), .rst(rst), .batch_start(batch_start), .base_index(base_index),
      .num_files(num_files), .abort(abort), .rot_start(rot_start), .rot_finish(rot_finish),
      .file_index(file_index), .busy(busy), .batch_done(batch_done),
      .timeout_err(timeout_err), .files_done(files_done), .state_dbg(state_dbg)
   );

   // Second instance: a stuck engine that never finishes.
   rotate_batch_scheduler #(.IDX_W(IDX_W), .TIMEOUT(16)) dut_s (
      .clk(clk), .rst(rst), .batch_start(s_start), .base_index(base_index),
      .num_files(num_files), .abort(abort), .rot_start(s_rot_start), .rot_finish(s_finish),
      .file_index(s_file_index), .busy(s_busy), .batch_done(s_batch_done),
      .timeout_err(s_timeout_err), .files_done(s_files_done), .state_dbg(s_state_dbg)
   );

   // ---------------- scoreboard ----------------
   logic [31:0] start_q[$];
   logic [31:0] done_q[$];
   int n_checks = 0;
   int n_fail   = 0;
   int n_starts = 0;
   int cyc = 0;
   int drop_cyc = 0;
   bit fin_q = 1'b0;
   bit gap_armed = 1'b0;
   bit intrude_req = 1'b0;
   int eng_lat = 0;
   int eng_hold = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Cycle bookkeeping: drop_cyc is the first cycle rot_finish is seen low after being high.
   always @(posedge clk) begin
      if (fin_q && !rot_finish) drop_cyc = cyc;
      fin_q = rot_finish;
      cyc = cyc + 1;
   end

   // Monitor: pops an expectation for every rot_start and batch_done pulse.
   always @(negedge clk) begin
      if (!rst) begin
         if (rot_start) begin
            n_starts++;
            if (gap_armed) check("issue_after_drop", cyc, drop_cyc + 1);
            gap_armed = 1'b1;
            if (start_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_rot_start: got index %0d, expected no start", file_index);
            end else begin
               check("rot_start_index", 32'(file_index), int'(start_q.pop_front()));
            end
         end
         if (batch_done) begin
            if (gap_armed) check("done_after_drop", cyc, drop_cyc + 1);
            if (done_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_batch_done: got files_done %0d, expected no done", files_done);
            end else begin
               check("batch_done_files", 32'(files_done), int'(done_q.pop_front()));
            end
         end
      end
   end

   // Rotate engine model: finish after eng_lat cycles, held eng_hold cycles (0 = random).
   int lat_v, hold_v;
   initial begin
      rot_finish = 1'b0;
      forever begin
         @(negedge clk);
         if (rot_start && !rst) begin
            lat_v  = (eng_lat  != 0) ? eng_lat  : int'($urandom_range(1, 12));
            hold_v = (eng_hold != 0) ? eng_hold : int'($urandom_range(1, 3));
            repeat (lat_v) @(negedge clk);
            rot_finish = 1'b1;
            repeat (hold_v) @(negedge clk);
            rot_finish = 1'b0;
         end
      end
   end

   // Intruder: a batch_start while the DUT is busy must be ignored.
   always @(negedge clk) begin
      if (intrude_req && rot_start && !rst) begin
         intrude_req = 1'b0;
         repeat (3) @(negedge clk);
         batch_start = 1'b1;
         base_index  = 10'd7;
         num_files   = 10'd2;
         @(negedge clk);
         batch_start = 1'b0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic check_reset_values(input string tag);
      check({tag, "_rot_start"},   32'(rot_start),   0);
      check({tag, "_file_index"},  32'(file_index),  0);
      check({tag, "_busy"},        32'(busy),        0);
      check({tag, "_batch_done"},  32'(batch_done),  0);
      check({tag, "_timeout_err"}, 32'(timeout_err), 0);
      check({tag, "_files_done"},  32'(files_done),  0);
   endtask

   task automatic run_batch(input int base, input int num, input bit intrude);
      int waited;
      gap_armed = 1'b0;
      for (int i = 0; i < num; i++) start_q.push_back(32'((base + i) % NIDX));
      done_q.push_back(32'(num));
      @(negedge clk);
      batch_start = 1'b1;
      base_index  = IDX_W'(base);
      num_files   = IDX_W'(num);
      intrude_req = intrude;
      @(negedge clk);
      batch_start = 1'b0;
      check("busy_cycle1", 32'(busy), 1);
      if (num == 0) begin
         check("zero_done_cycle1", 32'(batch_done), 1);
         check("zero_no_start", 32'(rot_start), 0);
      end else begin
         check("issue_cycle1", 32'(rot_start), 1);
      end
      waited = 0;
      while (!batch_done && waited < 400) begin
         @(negedge clk);
         waited++;
      end
      check("batch_done_within_bound", 32'(waited < 400), 1);
      @(negedge clk);
      check("idle_after_done", 32'(busy), 0);
      check("dbg_idle_after_done", 32'(state_dbg == ST_IDLE), 1);
      check("start_q_drained", start_q.size(), 0);
      check("done_q_drained", done_q.size(), 0);
      start_q.delete();
      done_q.delete();
   endtask

   task automatic stuck_test();
      bit saw_done;
      int extra_starts;
      saw_done = 1'b0;
      extra_starts = 0;
      @(negedge clk);
      base_index = 10'd77;
      num_files  = 10'd1;
      s_start    = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      check("stuck_issue", 32'(s_rot_start), 1);
      check("stuck_issue_index", 32'(s_file_index), 77);
      for (int c = 2; c <= 17; c++) begin
         @(negedge clk);
         if (s_batch_done) saw_done = 1'b1;
         if (s_rot_start) extra_starts++;
         if (c == 16) begin
            check("stuck_err_before", 32'(s_timeout_err), 0);
            check("stuck_busy_before", 32'(s_busy), 1);
         end
         if (c == 17) begin
            check("stuck_err_set", 32'(s_timeout_err), 1);
            check("stuck_busy_clear", 32'(s_busy), 0);
            check("stuck_dbg_idle", 32'(s_state_dbg == ST_IDLE), 1);
         end
      end
      check("stuck_no_done", 32'(saw_done), 0);
      check("stuck_single_start", extra_starts, 0);
      check("stuck_files_done", 32'(s_files_done), 0);
      repeat (3) @(negedge clk);
      check("stuck_err_sticky", 32'(s_timeout_err), 1);
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      check("stuck_err_cleared", 32'(s_timeout_err), 0);
      check("stuck_restart_issue", 32'(s_rot_start), 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("stuck_abort_idle", 32'(s_busy), 0);
   endtask

   task automatic abort_test();
      int waited, starts0;
      eng_lat = 4;
      eng_hold = 1;
      gap_armed = 1'b0;
      for (int i = 0; i < 5; i++) start_q.push_back(32'(100 + i));
      done_q.push_back(32'd5);
      @(negedge clk);
      batch_start = 1'b1;
      base_index  = 10'd100;
      num_files   = 10'd5;
      @(negedge clk);
      batch_start = 1'b0;
      waited = 0;
      while (!(rot_start && file_index == 10'd101) && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      check("abort_reach_file2", 32'(waited < 200), 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", 32'(busy), 0);
      check("abort_files_done", 32'(files_done), 1);
      check("abort_no_start", 32'(rot_start), 0);
      starts0 = n_starts;
      repeat (20) @(negedge clk);
      check("abort_no_more_starts", n_starts, starts0);
      check("abort_leftover_starts", start_q.size(), 3);
      check("abort_leftover_done", done_q.size(), 1);
      start_q.delete();
      done_q.delete();
   endtask

   task automatic reset_test();
      int waited, starts0;
      eng_lat = 10;
      eng_hold = 1;
      gap_armed = 1'b0;
      for (int i = 0; i < 3; i++) start_q.push_back(32'(200 + i));
      done_q.push_back(32'd3);
      @(negedge clk);
      batch_start = 1'b1;
      base_index  = 10'd200;
      num_files   = 10'd3;
      @(negedge clk);
      batch_start = 1'b0;
      waited = 0;
      while (!(rot_start && file_index == 10'd201) && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      check("reset_reach_file2", 32'(waited < 200), 1);
      repeat (4) @(negedge clk);
      check("reset_in_wait_busy", 32'(busy), 1);
      rst = 1'b1;
      #1;
      check_reset_values("midwait_reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      starts0 = n_starts;
      repeat (20) @(negedge clk);
      check("reset_no_more_starts", n_starts, starts0);
      check("reset_leftover_starts", start_q.size(), 1);
      start_q.delete();
      done_q.delete();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst = 1'b1;
      batch_start = 1'b0;
      base_index = '0;
      num_files = '0;
      abort = 1'b0;
      s_start = 1'b0;
      s_finish = 1'b0;
      #1;
      check_reset_values("por");
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      eng_lat = 20; eng_hold = 1;
      run_batch(5, 1, 1'b0);
      check("single_files_done", 32'(files_done), 1);

      eng_lat = 0; eng_hold = 1;
      run_batch(1021, 4, 1'b0);
      check("wrap_files_done", 32'(files_done), 4);

      eng_lat = 5; eng_hold = 3;
      run_batch(50, 2, 1'b0);

      run_batch(33, 0, 1'b0);
      check("zero_files_done", 32'(files_done), 0);

      eng_lat = 6; eng_hold = 0;
      run_batch(300, 3, 1'b1);

      eng_lat = 0; eng_hold = 0;
      for (int b = 0; b < 15; b++) begin
         int base, num;
         base = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1018, 1023))
                                            : int'($urandom_range(0, 1023));
         num = int'($urandom_range(0, 6));
         run_batch(base, num, 1'b0);
         check("rand_files_done", 32'(files_done), num);
      end

      stuck_test();
      abort_test();
      reset_test();

      eng_lat = 0; eng_hold = 0;
      run_batch(9, 2, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation exceeded its time budget");
      $fatal(1, "global timeout");
   end

endmodule
